// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: holds Cause/EPC and sequences exception entry and
// ERET return beside the Status register in the MEM stage.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   status         Status Q (BEV[22], IM[15:8], ERL[2], EXL[1], IE[0])
//   hw_int         asynchronous hardware interrupt lines -> IP[7:2]
//   exc_req/exc_code/exc_pc  synchronous exception request from MEM
//   int_pc         EPC used when an interrupt is taken
//   eret           ERET retiring in MEM
//   mtcd, cause_we, epc_we   mtc0 write data and enables
//   exl_next       next value for Status EXL
//   flush, redirect, redirect_pc, busy   pipeline control
//   cause, epc     CP0 Cause and EPC registers
//   count_we, compare_we, count, compare  timer (CP0_TIMER_EN only)
//
// Optional feature: define CP0_TIMER_EN to add the Count/Compare timer on IP[7].
module cp0_exception_ctrl #(
  parameter logic [31:0] VEC_BOOT    = 32'hBFC00380,
  parameter logic [31:0] VEC_NORM    = 32'h80000180,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] status,
  input  logic [5:0]  hw_int,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] int_pc,
  input  logic        eret,
  input  logic [31:0] mtcd,
  input  logic        cause_we,
  input  logic        epc_we,
`ifdef CP0_TIMER_EN
  input  logic        count_we,
  input  logic        compare_we,
  output logic [31:0] count,
  output logic [31:0] compare,
`endif
  output logic        exl_next,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  // Depth is clamped so a misconfigured instance still gets a safe synchronizer.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, ENTER, VECTOR, RETURN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  sync_q [SYNC_N];
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [7:0]  ip;
  logic        int_take;
  logic        accept_exc;
  logic        accept_int;
  logic        unused_status;

  assign unused_status = ^{status[31:23], status[21:16], status[7:3]};

  // hw_int synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_N; i++) sync_q[i] <= 6'd0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        timer_flag_q;

  // Free-running Count; flag raised on a Count/Compare match, cleared by a Compare write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_flag_q <= 1'b0;
    end else begin
      count_q <= count_we ? mtcd : count_q + 32'd1;
      if (compare_we) begin
        compare_q    <= mtcd;
        timer_flag_q <= 1'b0;
      end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
        timer_flag_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ip_hw   = {sync_q[SYNC_N-1][5] | timer_flag_q, sync_q[SYNC_N-1][4:0]};
`else
  assign ip_hw   = sync_q[SYNC_N-1];
`endif

  assign ip       = {ip_hw, ip_sw_q};
  assign int_take = status[0] & ~status[1] & ~status[2] & (|(ip & status[15:8]));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and sequencing outputs
  always_comb begin
    state_d     = state_q;
    accept_exc  = 1'b0;
    accept_int  = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    busy        = 1'b1;
    exl_next    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy     = 1'b0;
        exl_next = status[1];
        if (exc_req) begin
          accept_exc = 1'b1;
          state_d    = ENTER;
        end else if (int_take) begin
          accept_int = 1'b1;
          state_d    = ENTER;
        end else if (eret) begin
          state_d    = RETURN;
        end
      end
      ENTER: begin
        flush    = 1'b1;
        exl_next = 1'b1;
        state_d  = VECTOR;
      end
      VECTOR: begin
        redirect    = 1'b1;
        redirect_pc = status[22] ? VEC_BOOT : VEC_NORM;
        exl_next    = 1'b1;
        state_d     = IDLE;
      end
      RETURN: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cause/EPC updates; an accepted exception overrides an mtc0 EPC write,
  // and EPC is preserved for nested exceptions (EXL already set).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else if (state_q == IDLE) begin
      if (cause_we) ip_sw_q <= mtcd[9:8];
      if (accept_exc || accept_int) begin
        exc_code_q <= accept_exc ? exc_code : 5'd0;
        if (!status[1]) epc_q <= accept_exc ? exc_pc : int_pc;
      end else if (epc_we) begin
        epc_q <= mtcd;
      end
    end
  end

  assign cause = {16'd0, ip, 1'b0, exc_code_q, 2'b00};
  assign epc   = epc_q;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl: directed vector table, hand
// sequences for interrupt latency/masking/reset, and a randomized run against
// a queue-based reference model.
module tb_cp0_exception_ctrl;

  localparam logic [31:0] VB = 32'hBFC00380;
  localparam logic [31:0] VN = 32'h80000180;
  localparam int unsigned NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] status;
  logic [5:0]  hw_int;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, int_pc, mtcd;
  logic        eret, cause_we, epc_we;
  logic        exl_next, flush, redirect, busy;
  logic [31:0] redirect_pc, cause, epc;
`ifdef CP0_TIMER_EN
  logic        count_we = 1'b0, compare_we = 1'b0;
  logic [31:0] count, compare;
`endif

  int tests = 0;
  int fails = 0;

  cp0_exception_ctrl #(.VEC_BOOT(VB), .VEC_NORM(VN), .SYNC_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .status(status), .hw_int(hw_int),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .int_pc(int_pc),
    .eret(eret), .mtcd(mtcd), .cause_we(cause_we), .epc_we(epc_we),
`ifdef CP0_TIMER_EN
    .count_we(count_we), .compare_we(compare_we), .count(count), .compare(compare),
`endif
    .exl_next(exl_next), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .cause(cause), .epc(epc));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A taken event becomes a list of per-cycle output slots; busy = slots pending.
  typedef struct packed {
    logic       fl;
    logic       rd;
    logic       ex;
    logic [1:0] kind;   // 0: pc 0, 1: exception vector, 2: EPC
  } slot_t;

  slot_t       mq[$];
  logic [5:0]  hq[$];
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [31:0] m_epc;

  function automatic slot_t mk(logic f, logic r, logic e, logic [1:0] k);
    slot_t s;
    s.fl = f; s.rd = r; s.ex = e; s.kind = k;
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    hq.delete();
    for (int i = 0; i < int'(NS); i++) hq.push_back(6'd0);
    m_ipsw = 2'd0;
    m_code = 5'd0;
    m_epc  = 32'd0;
  endtask

  task automatic model_edge();
    logic [7:0] ipv;
    logic       itake;
    if (mq.size() == 0) begin
      ipv   = {hq[0], m_ipsw};
      itake = status[0] && !status[1] && !status[2] && ((ipv & status[15:8]) != 8'd0);
      if (exc_req || itake) begin
        mq.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0));
        mq.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1));
        m_code = exc_req ? exc_code : 5'd0;
        if (!status[1]) m_epc = exc_req ? exc_pc : int_pc;
      end else begin
        if (eret) mq.push_back(mk(1'b1, 1'b1, 1'b0, 2'd2));
        if (epc_we) m_epc = mtcd;
      end
      if (cause_we) m_ipsw = mtcd[9:8];
    end else begin
      void'(mq.pop_front());
    end
    hq.push_back(hw_int);
    void'(hq.pop_front());
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    logic        e_fl, e_rd, e_ex, e_busy;
    logic [31:0] e_pc;
    e_busy = (mq.size() != 0);
    e_fl = 1'b0; e_rd = 1'b0; e_pc = 32'd0; e_ex = status[1];
    if (e_busy) begin
      e_fl = mq[0].fl;
      e_rd = mq[0].rd;
      e_ex = mq[0].ex;
      e_pc = (mq[0].kind == 2'd1) ? (status[22] ? VB : VN) :
             (mq[0].kind == 2'd2) ? m_epc : 32'd0;
    end
    chk({tag, ".busy"},  32'(busy), 32'(e_busy));
    chk({tag, ".flush"}, 32'(flush), 32'(e_fl));
    chk({tag, ".redir"}, 32'(redirect), 32'(e_rd));
    chk({tag, ".rpc"},   redirect_pc, e_pc);
    chk({tag, ".exl"},   32'(exl_next), 32'(e_ex));
    chk({tag, ".epc"},   epc, m_epc);
    chk({tag, ".cause"}, cause, {16'd0, hq[0], m_ipsw, 1'b0, m_code, 2'b00});
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step(string tag);
    #1 check_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_pulses();
    exc_req = 1'b0; eret = 1'b0; cause_we = 1'b0; epc_we = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  // Inputs applied for one cycle; expectations checked just after the edge.
  typedef struct packed {
    logic [31:0] st;
    logic        xr;
    logic [4:0]  xc;
    logic [31:0] xpc;
    logic        er;
    logic [31:0] md;
    logic        cwe;
    logic        ewe;
    logic        e_fl;
    logic        e_rd;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_ex;
    logic [31:0] e_epc;
    logic [31:0] e_cause;
  } vec_t;

  localparam int NV = 22;
  vec_t v [NV];

  initial begin
    v[0]  = '{32'h0000FF01, 1'b1, 5'd8,  32'h00400010, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400010, 32'h20};
    v[1]  = '{32'h0000FF01, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, VN,           1'b1, 1'b1, 32'h00400010, 32'h20};
    v[2]  = '{32'h0000FF01, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400010, 32'h20};
    v[3]  = '{32'h0000FF03, 1'b0, 5'd0,  32'h0,        1'b0, 32'h1234,     1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1234,     32'h20};
    v[4]  = '{32'h0000FF03, 1'b1, 5'd4,  32'h0000DEAD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1234,     32'h10};
    v[5]  = '{32'h0000FF03, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, VN,           1'b1, 1'b1, 32'h1234,     32'h10};
    v[6]  = '{32'h0000FF03, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1234,     32'h10};
    v[7]  = '{32'h00000002, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00400020, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400020, 32'h10};
    v[8]  = '{32'h00000000, 1'b1, 5'd12, 32'h00400030, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400030, 32'h30};
    v[9]  = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, VN,           1'b1, 1'b1, 32'h00400030, 32'h30};
    v[10] = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400030, 32'h30};
    v[11] = '{32'h00000002, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00400020, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400020, 32'h30};
    v[12] = '{32'h00000002, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h00400020, 1'b1, 1'b0, 32'h00400020, 32'h30};
    v[13] = '{32'h00000002, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400020, 32'h30};
    v[14] = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00000300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400020, 32'h330};
    v[15] = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400020, 32'h30};
    v[16] = '{32'h00000000, 1'b1, 5'd1,  32'h00000100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h4};
    v[17] = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, VN,           1'b1, 1'b1, 32'h100,      32'h4};
    v[18] = '{32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      32'h4};
    v[19] = '{32'h00400000, 1'b1, 5'd2,  32'h00000200, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h8};
    v[20] = '{32'h00400000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, VB,           1'b1, 1'b1, 32'h200,      32'h8};
    v[21] = '{32'h00400000, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h200,      32'h8};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; status = 32'd0; hw_int = 6'd0; exc_code = 5'd0;
    exc_pc = 32'd0; int_pc = 32'h00400044; mtcd = 32'd0;
    clear_pulses();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.redir", 32'(redirect), 32'd0);
    chk("rst.rpc", redirect_pc, 32'd0);
    chk("rst.cause", cause, 32'd0);
    chk("rst.epc", epc, 32'd0);
    chk("rst.exl", 32'(exl_next), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      status = v[i].st; exc_req = v[i].xr; exc_code = v[i].xc; exc_pc = v[i].xpc;
      eret = v[i].er; mtcd = v[i].md; cause_we = v[i].cwe; epc_we = v[i].ewe;
      step($sformatf("v%0d.pre", i));
      clear_pulses();
      #1;
      chk($sformatf("v%0d.flush", i), 32'(flush), 32'(v[i].e_fl));
      chk($sformatf("v%0d.redir", i), 32'(redirect), 32'(v[i].e_rd));
      chk($sformatf("v%0d.rpc", i), redirect_pc, v[i].e_pc);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(v[i].e_busy));
      chk($sformatf("v%0d.exl", i), 32'(exl_next), 32'(v[i].e_ex));
      chk($sformatf("v%0d.epc", i), epc, v[i].e_epc);
      chk($sformatf("v%0d.cause", i), cause, v[i].e_cause);
    end

    // Interrupt latency and entry with BEV=1
    status = 32'h00400401; hw_int = 6'd1;
    step("int0");
    chk("int.ip_lat1", 32'(cause[10]), 32'd0);
    step("int1");
    chk("int.ip_lat2", 32'(cause[10]), 32'd1);
    chk("int.idle", 32'(busy), 32'd0);
    step("int2");
    chk("int.enter", 32'(flush), 32'd1);
    chk("int.code", 32'(cause[6:2]), 32'd0);
    chk("int.epc", epc, 32'h00400044);
    status = 32'h00400403;
    step("int3");
    chk("int.vec", redirect_pc, VB);
    // EXL, IM=0 and ERL each mask the pending interrupt
    for (int k = 0; k < 3; k++) begin
      status = (k == 0) ? 32'h00400403 : (k == 1) ? 32'h00000001 : 32'h00000405;
      for (int c = 0; c < 3; c++) begin
        step($sformatf("mask%0d", k));
        chk($sformatf("mask%0d.busy", k), 32'(busy), 32'd0);
        chk($sformatf("mask%0d.ip", k), 32'(cause[10]), 32'd1);
      end
    end
    // ERL does not mask exc_req
    exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h00400050;
    step("erl_exc");
    clear_pulses();
    #1 chk("erl_exc.busy", 32'(busy), 32'd1);
    step("erl_vec");
    hw_int = 6'd0; status = 32'd0;
    for (int c = 0; c < 3; c++) step("drain");

    // Reset mid-ENTER
    exc_req = 1'b1; exc_code = 5'd3; exc_pc = 32'h00400060;
    step("rmid");
    clear_pulses();
    #1 chk("rmid.flush", 32'(flush), 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.flush0", 32'(flush), 32'd0);
    chk("rmid.redir", 32'(redirect), 32'd0);
    chk("rmid.epc", epc, 32'd0);
    chk("rmid.cause", cause, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("rpost");
    chk("rpost.busy", 32'(busy), 32'd0);

    // Randomized run against the model
    for (int n = 0; n < 2000; n++) begin
      status   = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      exc_req  = ($urandom_range(0, 7) == 0);
      exc_code = 5'($urandom);
      exc_pc   = $urandom;
      int_pc   = $urandom;
      eret     = ($urandom_range(0, 5) == 0);
      mtcd     = $urandom;
      cause_we = ($urandom_range(0, 7) == 0);
      epc_we   = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
